// File: rtl/lstm_axi_vec_loader.sv
// AXI4 read master that fetches a word vector in INCR bursts
// and streams it through a small FIFO to the LSTM datapath.
module lstm_axi_vec_loader #(
  parameter int ADDR_W     = 12,
  parameter int DATA_W     = 32,
  parameter int MAX_BURST  = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              sys_clock,
  input  logic              reset_rtl,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [8:0]        num_words,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] M_AXI_araddr,
  output logic [7:0]        M_AXI_arlen,
  output logic [2:0]        M_AXI_arsize,
  output logic [1:0]        M_AXI_arburst,
  output logic              M_AXI_arvalid,
  input  logic              M_AXI_arready,
  input  logic [DATA_W-1:0] M_AXI_rdata,
  input  logic [1:0]        M_AXI_rresp,
  input  logic              M_AXI_rlast,
  input  logic              M_AXI_rvalid,
  output logic              M_AXI_rready,
  output logic [DATA_W-1:0] vec_data,
  output logic              vec_valid,
  input  logic              vec_ready,
  output logic              vec_last
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CHECK = 3'd1;
  localparam logic [2:0] S_ADDR  = 3'd2;
  localparam logic [2:0] S_DATA  = 3'd3;
  localparam logic [2:0] S_DRAIN = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(FIFO_DEPTH);
  localparam logic [8:0] MAXB = 9'(MAX_BURST);
  localparam logic [ADDR_W+1:0] ADDR_LIM =
    {2'b01, {ADDR_W{1'b0}}};

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [8:0]        rem_q, rem_d;
  logic [8:0]        beats_q, beats_d;
  logic [7:0]        arlen_q, arlen_d;
  logic              err_q, err_d;
  logic [8:0]        pop_left_q, pop_left_d;

  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PW:0]       cnt_q, cnt_d;

  logic fifo_full, fifo_empty, push, pop;
  logic bad_req, last_beat;
  logic [ADDR_W+1:0] end_addr;

  function automatic logic [7:0] len_of(input logic [8:0] r);
    logic [8:0] n;
    n = (r > MAXB) ? MAXB : r;
    return 8'(n - 9'd1);
  endfunction

  assign fifo_full  = (cnt_q == FULL_CNT);
  assign fifo_empty = (cnt_q == '0);
  assign push = M_AXI_rvalid && M_AXI_rready;
  assign pop  = vec_valid && vec_ready;

  assign end_addr = {2'b00, addr_q}
                  + (ADDR_W+2)'({rem_q, 2'b00});
  assign bad_req = (addr_q[1:0] != 2'b00)
                || (rem_q == 9'd0)
                || (end_addr > ADDR_LIM);
  assign last_beat = (beats_q == 9'd1);

  assign busy = (state_q == S_CHECK) || (state_q == S_ADDR)
             || (state_q == S_DATA) || (state_q == S_DRAIN);
  assign done = (state_q == S_DONE);
  assign err  = err_q;

  assign M_AXI_araddr  = addr_q;
  assign M_AXI_arlen   = arlen_q;
  assign M_AXI_arsize  = 3'b010;
  assign M_AXI_arburst = 2'b01;
  assign M_AXI_arvalid = (state_q == S_ADDR);
  assign M_AXI_rready  = (state_q == S_DATA) && !fifo_full;

  assign vec_valid = !fifo_empty;
  assign vec_data  = mem_q[rd_ptr_q];
  assign vec_last  = vec_valid && (pop_left_q == 9'd1);

  // Transfer sequencing: request check, bursts, drain, done
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    rem_d      = rem_q;
    beats_d    = beats_q;
    arlen_d    = arlen_q;
    err_d      = err_q;
    pop_left_d = pop_left_q;
    if (pop) pop_left_d = pop_left_q - 9'd1;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          addr_d     = base_addr;
          rem_d      = num_words;
          pop_left_d = num_words;
          err_d      = 1'b0;
          state_d    = S_CHECK;
        end
      end
      S_CHECK: begin
        if (bad_req) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          arlen_d = len_of(rem_q);
          state_d = S_ADDR;
        end
      end
      S_ADDR: begin
        if (M_AXI_arready) begin
          beats_d = {1'b0, arlen_q} + 9'd1;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (push) begin
          rem_d   = rem_q - 9'd1;
          beats_d = beats_q - 9'd1;
          addr_d  = addr_q + ADDR_W'(4);
          if (M_AXI_rresp != 2'b00) err_d = 1'b1;
          if (M_AXI_rlast != last_beat) err_d = 1'b1;
          if (last_beat) begin
            if (rem_q != 9'd1) begin
              arlen_d = len_of(rem_q - 9'd1);
              state_d = S_ADDR;
            end else begin
              state_d = S_DRAIN;
            end
          end
        end
      end
      S_DRAIN: begin
        if (fifo_empty) state_d = S_DONE;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FIFO pointer and occupancy update
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    if (push && !pop) cnt_d = cnt_q + (PW+1)'(1);
    if (!push && pop) cnt_d = cnt_q - (PW+1)'(1);
  end

  // Control state registers
  always_ff @(posedge sys_clock or negedge reset_rtl) begin
    if (!reset_rtl) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      rem_q      <= '0;
      beats_q    <= '0;
      arlen_q    <= '0;
      err_q      <= 1'b0;
      pop_left_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      rem_q      <= rem_d;
      beats_q    <= beats_d;
      arlen_q    <= arlen_d;
      err_q      <= err_d;
      pop_left_q <= pop_left_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
    end
  end

  // FIFO storage, written on each accepted read beat
  always_ff @(posedge sys_clock) begin
    if (push) mem_q[wr_ptr_q] <= M_AXI_rdata;
  end

endmodule

// File: tb/tb_lstm_axi_vec_loader.sv
// Randomized bench: AXI slave model, expected-word scoreboard
// and a vector monitor that compares every popped word.
module tb_lstm_axi_vec_loader;

  logic        sys_clock = 1'b0;
  logic        reset_rtl = 1'b1;
  logic        start = 1'b0;
  logic [11:0] base_addr = '0;
  logic [8:0]  num_words = '0;
  logic        busy, done, err;
  logic [11:0] M_AXI_araddr;
  logic [7:0]  M_AXI_arlen;
  logic [2:0]  M_AXI_arsize;
  logic [1:0]  M_AXI_arburst;
  logic        M_AXI_arvalid;
  logic        M_AXI_arready = 1'b0;
  logic [31:0] M_AXI_rdata = '0;
  logic [1:0]  M_AXI_rresp = '0;
  logic        M_AXI_rlast = 1'b0;
  logic        M_AXI_rvalid = 1'b0;
  logic        M_AXI_rready;
  logic [31:0] vec_data;
  logic        vec_valid;
  logic        vec_ready = 1'b0;
  logic        vec_last;

  lstm_axi_vec_loader dut (
    .sys_clock(sys_clock), .reset_rtl(reset_rtl),
    .start(start), .base_addr(base_addr),
    .num_words(num_words), .busy(busy), .done(done),
    .err(err), .M_AXI_araddr(M_AXI_araddr),
    .M_AXI_arlen(M_AXI_arlen), .M_AXI_arsize(M_AXI_arsize),
    .M_AXI_arburst(M_AXI_arburst),
    .M_AXI_arvalid(M_AXI_arvalid),
    .M_AXI_arready(M_AXI_arready),
    .M_AXI_rdata(M_AXI_rdata), .M_AXI_rresp(M_AXI_rresp),
    .M_AXI_rlast(M_AXI_rlast), .M_AXI_rvalid(M_AXI_rvalid),
    .M_AXI_rready(M_AXI_rready), .vec_data(vec_data),
    .vec_valid(vec_valid), .vec_ready(vec_ready),
    .vec_last(vec_last)
  );

  always #5 sys_clock = ~sys_clock;

  typedef struct packed {
    logic [31:0] d;
    logic        l;
  } vexp_t;
  typedef struct packed {
    logic [11:0] a;
    logic [7:0]  l;
  } ar_t;
  typedef struct packed {
    logic [31:0] d;
    logic [1:0]  r;
    logic        l;
  } beat_t;

  vexp_t exp_q[$];
  ar_t   ar_q[$];
  beat_t beats[$];
  logic [31:0] mem [1024];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int st_cyc, first_ar_cyc, last_pop_cyc, done_cyc;
  int done_cnt = 0;
  int beats_acc = 0;
  int beat_idx = 0;
  int err_beat = -1;
  bit nolast = 0;
  bit hold = 0;
  bit fast = 0;
  bit r_fire_prev = 0;
  bit exp_err;
  bit exp_bad;

  always @(posedge sys_clock) cyc <= cyc + 1;

  task automatic chk(input string nm,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", nm, got, exp);
    end
  endtask

  // AXI read slave: random arready, random rvalid gaps
  always @(negedge sys_clock) begin
    if (!reset_rtl) begin
      M_AXI_rvalid = 1'b0;
      M_AXI_arready = 1'b0;
      r_fire_prev = 0;
    end else begin
      if (r_fire_prev) begin
        if (beats.size() > 0) void'(beats.pop_front());
        beats_acc++;
        M_AXI_rvalid = 1'b0;
      end
      if (beats.size() > 0) begin
        if (!M_AXI_rvalid)
          M_AXI_rvalid = fast || ($urandom % 4 != 0);
        M_AXI_rdata = beats[0].d;
        M_AXI_rresp = beats[0].r;
        M_AXI_rlast = beats[0].l;
      end else begin
        M_AXI_rvalid = 1'b0;
      end
      r_fire_prev = M_AXI_rvalid && M_AXI_rready;
      M_AXI_arready = ($urandom % 2) == 1;
      if (M_AXI_arvalid && M_AXI_arready) begin
        if (ar_q.size() == 0) begin
          chk("ar_unexpected", 1, 0);
        end else begin
          ar_t e;
          e = ar_q.pop_front();
          chk("araddr", M_AXI_araddr, e.a);
          chk("arlen", M_AXI_arlen, e.l);
        end
        chk("arsize", M_AXI_arsize, 3'b010);
        chk("arburst", M_AXI_arburst, 2'b01);
        for (int i = 0; i <= int'(M_AXI_arlen); i++) begin
          beat_t b;
          b.d = mem[(int'(M_AXI_araddr) >> 2) + i];
          b.r = (beat_idx == err_beat) ? 2'b10 : 2'b00;
          b.l = (i == int'(M_AXI_arlen)) && !nolast;
          beat_idx++;
          beats.push_back(b);
        end
      end
    end
  end

  // Vector monitor: pops the scoreboard on each handshake
  always @(negedge sys_clock) begin
    if (!reset_rtl) begin
      vec_ready = 1'b0;
    end else begin
      vec_ready = !hold && ($urandom % 4 != 0);
      if (vec_valid && vec_ready) begin
        if (exp_q.size() == 0) begin
          chk("vec_unexpected", 1, 0);
        end else begin
          vexp_t e;
          e = exp_q.pop_front();
          chk("vec_data", vec_data, e.d);
          chk("vec_last", vec_last, e.l);
          if (e.l) last_pop_cyc = cyc;
        end
      end
      if (M_AXI_arvalid && first_ar_cyc < 0)
        first_ar_cyc = cyc;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  task automatic issue(input int base, input int num,
                       input int rerr, input bit nl);
    int a, r, l;
    exp_bad = (base % 4 != 0) || (num == 0)
           || (base + 4 * num > 4096);
    exp_err = exp_bad || (rerr >= 0 && rerr < num) || nl;
    if (!exp_bad) begin
      for (int i = 0; i < num; i++) begin
        vexp_t v;
        v.d = mem[base / 4 + i];
        v.l = (i == num - 1);
        exp_q.push_back(v);
      end
      a = base;
      r = num;
      while (r > 0) begin
        ar_t t;
        l = (r > 16) ? 16 : r;
        t.a = 12'(a);
        t.l = 8'(l - 1);
        ar_q.push_back(t);
        a += 4 * l;
        r -= l;
      end
    end
    err_beat = rerr;
    nolast = nl;
    beat_idx = 0;
    first_ar_cyc = -1;
    last_pop_cyc = -100;
    @(negedge sys_clock);
    start = 1'b1;
    base_addr = 12'(base);
    num_words = 9'(num);
    st_cyc = cyc;
    @(negedge sys_clock);
    start = 1'b0;
  endtask

  task automatic finish_run();
    int d0;
    bit seen;
    d0 = done_cnt;
    seen = 0;
    for (int k = 0; k < 4000 && !seen; k++) begin
      @(negedge sys_clock);
      #1;
      if (done_cnt != d0) seen = 1;
    end
    chk("done_seen", seen, 1);
    if (seen) begin
      chk("err_flag", err, exp_err);
      if (exp_bad) begin
        chk("bad_done_lat", done_cyc - st_cyc, 2);
        chk("bad_no_ar", first_ar_cyc < 0, 1);
      end else begin
        chk("ar_lat", first_ar_cyc - st_cyc, 2);
        chk("done_lat", done_cyc - last_pop_cyc, 2);
        chk("words_left", exp_q.size(), 0);
        chk("ars_left", ar_q.size(), 0);
      end
      @(negedge sys_clock);
      #1;
      chk("busy_after", busy, 0);
    end
  endtask

  task automatic run(input int base, input int num,
                     input int rerr, input bit nl);
    issue(base, num, rerr, nl);
    finish_run();
  endtask

  task automatic check_reset_outs();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_arvalid", M_AXI_arvalid, 0);
    chk("rst_rready", M_AXI_rready, 0);
    chk("rst_vec_valid", vec_valid, 0);
    chk("rst_vec_last", vec_last, 0);
    chk("rst_araddr", M_AXI_araddr, 0);
    chk("rst_arlen", M_AXI_arlen, 0);
  endtask

  initial begin
    int acc0, d0, b, n;
    for (int i = 0; i < 1024; i++) mem[i] = $urandom;
    mem[12'h100 / 4] = 32'hDEADBEEF;
    #1 reset_rtl = 1'b0;
    #2 check_reset_outs();
    repeat (3) @(negedge sys_clock);
    #2 reset_rtl = 1'b1;

    run(12'h100, 1, -1, 0);
    run(0, 40, -1, 0);

    hold = 1;
    fast = 1;
    acc0 = beats_acc;
    issue(12'h200, 16, -1, 0);
    repeat (20) @(negedge sys_clock);
    #1;
    chk("hold_beats", beats_acc - acc0, 4);
    chk("hold_rready", M_AXI_rready, 0);
    hold = 0;
    fast = 0;
    finish_run();

    run(12'h102, 1, -1, 0);
    run(0, 0, -1, 0);
    run(12'hFF0, 8, -1, 0);
    run(12'hFE0, 8, -1, 0);

    run(12'h040, 5, 2, 0);
    run(12'h080, 5, -1, 0);
    run(12'h0C0, 20, -1, 1);

    for (int t = 0; t < 10; t++) begin
      n = 1 + int'($urandom % 48);
      b = 4 * int'($urandom % (1025 - n));
      run(b, n, ($urandom % 3 == 0) ? int'($urandom % n) : -1, 0);
    end

    fast = 1;
    acc0 = beats_acc;
    issue(12'h300, 16, -1, 0);
    for (int k = 0; k < 200 && beats_acc - acc0 < 4; k++) begin
      @(negedge sys_clock);
      #1;
    end
    chk("mid_reached", beats_acc - acc0 >= 4, 1);
    #1 reset_rtl = 1'b0;
    #1 check_reset_outs();
    exp_q.delete();
    ar_q.delete();
    beats.delete();
    r_fire_prev = 0;
    fast = 0;
    repeat (3) @(negedge sys_clock);
    #2 reset_rtl = 1'b1;
    d0 = done_cnt;
    repeat (5) @(negedge sys_clock);
    chk("no_done_after_rst", done_cnt - d0, 0);
    run(12'h010, 2, -1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lstm_axi_vec_loader.md
LSTM_AXI_VEC_LOADER -- requirements
Module: lstm_axi_vec_loader

Interface
REQ-001 Parameters SHALL be:
- ADDR_W, 12, AXI address width.
- DATA_W, 32, AXI and stream data width.
- MAX_BURST, 16, maximum beats per AR burst (1..256).
- FIFO_DEPTH, 4, read-data buffer entries (power of 2).

REQ-002 Ports SHALL be (name  direction  width  meaning):
- sys_clock  in  1  single clock; all logic on rising edge.
- reset_rtl  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to load a vector.
- base_addr  in  12  byte address of first word.
- num_words  in  9  word count, 1..256.
- busy  out  1  transfer in progress.
- done  out  1  one-cycle completion pulse.
- err  out  1  sticky error flag; cleared by next accepted start.
- M_AXI_araddr  out  12  burst start address.
- M_AXI_arlen  out  8  beats-1.
- M_AXI_arsize  out  3  constant 3'b010.
- M_AXI_arburst  out  2  constant 2'b01 (INCR).
- M_AXI_arvalid  out  1  address valid.
- M_AXI_arready  in  1  address accepted.
- M_AXI_rdata  in  32  read data.
- M_AXI_rresp  in  2  read response.
- M_AXI_rlast  in  1  last beat of burst.
- M_AXI_rvalid  in  1  read data valid.
- M_AXI_rready  out  1  read data accept.
- vec_data  out  32  word to LSTM datapath.
- vec_valid  out  1  vec_data valid.
- vec_ready  in  1  downstream accept.
- vec_last  out  1  marks final word of the vector.

Function
REQ-003 The block SHALL act as the AXI4 read master feeding one slave port of memory_block_wrapper, streaming fetched words to the LSTM datapath.
REQ-004 The FSM SHALL have states IDLE, CHECK, ADDR, DATA, DRAIN and DONE.
REQ-005 In IDLE with start=1, the block SHALL latch base_addr/num_words, clear err, set busy, and enter CHECK; start SHALL be ignored in every other state.
REQ-006 CHECK SHALL flag err and go to DONE, issuing no AR, if base_addr[1:0]!=0, num_words==0, or base_addr+4*num_words>4096; otherwise it SHALL go to ADDR.
REQ-007 ADDR SHALL drive arvalid=1 with araddr=current address and arlen=min(remaining,MAX_BURST)-1, holding all AR signals stable until arready; the handshake SHALL move the FSM to DATA.
REQ-008 M_AXI_rready SHALL equal (state==DATA) AND FIFO not full; each accepted beat SHALL be pushed into the FIFO, decrement remaining, and add 4 to the current address.
REQ-009 On the beat where the burst count expires, the FSM SHALL go to ADDR if remaining>0, else to DRAIN; only one AR SHALL be outstanding at any time.
REQ-010 rresp!=2'b00 on any beat SHALL set err; the data SHALL still be forwarded and the transfer SHALL continue.
REQ-011 rlast mismatching the expected final beat (early or missing) SHALL set err; beat counting, not rlast, SHALL govern progress.
REQ-012 vec_valid SHALL equal FIFO not empty; a pop SHALL occur on vec_valid&vec_ready; a simultaneous push and pop on a full FIFO SHALL be permitted.
REQ-013 vec_last SHALL be 1 exactly on the num_words-th word popped.
REQ-014 DRAIN SHALL wait until the FIFO is empty, then enter DONE.
REQ-015 DONE SHALL assert done=1 for one cycle, drop busy, and return to IDLE.
REQ-016 Latency: start -> arvalid=1 SHALL be 2 cycles; the final pop -> done SHALL be 2 cycles.

Reset
REQ-017 reset_rtl=0 SHALL asynchronously force IDLE, empty the FIFO, and drive busy, done, err, arvalid, rready, vec_valid and vec_last to 0, and araddr and arlen to 0.
REQ-018 Reset mid-transfer SHALL abandon the transfer without a done pulse; beats arriving after release SHALL be ignored (rready=0 in IDLE).

Verification
REQ-019 start with base=0x100, num=1, slave returns 0xDEADBEEF -> one AR (addr 0x100, len 0); vec_data=0xDEADBEEF with vec_last=1; done pulse; err=0.
REQ-020 base=0x000, num=40, MAX_BURST=16 -> ARs at 0x000/len15, 0x040/len15, 0x080/len7; 40 words in order; vec_last on the 40th.
REQ-021 vec_ready held 0 for 20 cycles during a 16-beat burst -> rready drops after 4 beats; no data lost or reordered after vec_ready returns to 1.
REQ-022 base=0x102, or num=0, or base=0xFF0 with num=8 -> no arvalid; err=1; done pulse 2 cycles after start.
REQ-023 rresp=2'b10 on beat 3 of 5 -> all 5 words delivered, err=1, done pulse; a second clean start clears err.
REQ-024 reset_rtl low during beat 5 of 16 -> all outputs 0 immediately; after release, a fresh start with num=2 completes normally.
